// File: rtl/lutram_readback_checker.sv
// rtl/lutram_readback_checker.sv - checks a LUTRAM readback stream and reports pass/fail as level and blink
// Optional first-error capture ports: define LUTRAM_CHECK_FIRST_ERR_EN.
module lutram_readback_checker #(
  parameter int unsigned A_WIDTH      = 6,
  parameter int unsigned D_WIDTH      = 1,
  parameter int unsigned BLINK_CYCLES = 24'd12500000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               valid_i,
  input  logic [A_WIDTH-1:0] addr_i,
  input  logic [D_WIDTH-1:0] data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [A_WIDTH:0]   err_count_o,
  output logic               blink_o
`ifdef LUTRAM_CHECK_FIRST_ERR_EN
  ,
  output logic [A_WIDTH-1:0] first_err_addr_o,
  output logic [D_WIDTH-1:0] first_err_data_o
`endif
);

  localparam int unsigned   CW       = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] BLINK_TC = CW'(BLINK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [A_WIDTH:0] LAST_IDX = {1'b0, {A_WIDTH{1'b1}}};
  localparam logic [A_WIDTH:0] ERR_MAX  = {(A_WIDTH+1){1'b1}};
  localparam logic [A_WIDTH:0] IDX_ONE  = {{A_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_PASS, S_FAIL} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [A_WIDTH:0]   r_idx;
  logic [A_WIDTH:0]   r_err_count;
  logic [A_WIDTH:0]   w_err_next;
  logic [CW-1:0]      r_blink_cnt;
  logic               r_blink;
  logic [D_WIDTH-1:0] w_exp_data;
  logic               w_sample;
  logic               w_bad;
  logic               w_last;

  // start_i wins over a coincident sample, so the sample is never evaluated
  assign w_sample   = (r_state == S_CHECK) && valid_i && !start_i;
  assign w_exp_data = D_WIDTH'(r_idx[A_WIDTH-1:0]);
  assign w_bad      = w_sample && (({1'b0, addr_i} != r_idx) || (data_i != w_exp_data));
  assign w_last     = w_sample && (r_idx == LAST_IDX);
  assign w_err_next = (w_bad && (r_err_count != ERR_MAX)) ? r_err_count + IDX_ONE : r_err_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (start_i) begin
      w_state_next = S_CHECK;
    end else if (w_last) begin
      w_state_next = (w_err_next == '0) ? S_PASS : S_FAIL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx       <= '0;
      r_err_count <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (start_i) begin
      r_idx       <= '0;
      r_err_count <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else begin
      if (w_sample) begin
        r_idx       <= r_idx + IDX_ONE;
        r_err_count <= w_err_next;
      end
      if (r_state == S_FAIL) begin
        if (r_blink_cnt == BLINK_TC) begin
          r_blink_cnt <= '0;
          r_blink     <= ~r_blink;
        end else begin
          r_blink_cnt <= r_blink_cnt + CNT_ONE;
        end
      end
    end
  end

`ifdef LUTRAM_CHECK_FIRST_ERR_EN
  logic [A_WIDTH-1:0] r_first_err_addr;
  logic [D_WIDTH-1:0] r_first_err_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
    end else if (start_i) begin
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
    end else if (w_bad && (r_err_count == '0)) begin
      r_first_err_addr <= addr_i;
      r_first_err_data <= data_i;
    end
  end

  assign first_err_addr_o = r_first_err_addr;
  assign first_err_data_o = r_first_err_data;
`endif

  assign busy_o      = (r_state == S_CHECK);
  assign done_o      = (r_state == S_PASS) || (r_state == S_FAIL);
  assign pass_o      = (r_state == S_PASS);
  assign err_count_o = r_err_count;
  assign blink_o     = (r_state == S_PASS) || r_blink;

endmodule

// File: tb/tb_lutram_readback_checker.sv
// tb/tb_lutram_readback_checker.sv - randomized self-checking bench for lutram_readback_checker
// Optional first-error ports are checked when LUTRAM_CHECK_FIRST_ERR_EN is defined.
module tb_lutram_readback_checker;

  localparam int A1 = 6, D1 = 1, B1 = 4, N1 = 64;
  localparam int A2 = 2, D2 = 3, B2 = 2, N2 = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic          st1, v1, busy1, done1, pass1, blink1;
  logic [A1-1:0] a1;
  logic [D1-1:0] d1;
  logic [A1:0]   ec1;
  logic          st2, v2, busy2, done2, pass2, blink2;
  logic [A2-1:0] a2;
  logic [D2-1:0] d2;
  logic [A2:0]   ec2;
`ifdef LUTRAM_CHECK_FIRST_ERR_EN
  logic [A1-1:0] fa1;
  logic [D1-1:0] fd1;
  logic [A2-1:0] fa2;
  logic [D2-1:0] fd2;
`endif

  int vecs = 0;
  int errs = 0;
  int s_addr[64];
  int s_data[64];

  always #5 clk = ~clk;

  lutram_readback_checker #(.A_WIDTH(A1), .D_WIDTH(D1), .BLINK_CYCLES(B1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st1), .valid_i(v1), .addr_i(a1), .data_i(d1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(ec1), .blink_o(blink1)
`ifdef LUTRAM_CHECK_FIRST_ERR_EN
    , .first_err_addr_o(fa1), .first_err_data_o(fd1)
`endif
  );

  lutram_readback_checker #(.A_WIDTH(A2), .D_WIDTH(D2), .BLINK_CYCLES(B2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st2), .valid_i(v2), .addr_i(a2), .data_i(d2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(ec2), .blink_o(blink2)
`ifdef LUTRAM_CHECK_FIRST_ERR_EN
    , .first_err_addr_o(fa2), .first_err_data_o(fd2)
`endif
  );

  task automatic set_in(input int sel, input logic st, input logic v, input int a, input int d);
    if (sel == 1) begin
      st1 = st; v1 = v; a1 = a[A1-1:0]; d1 = d[D1-1:0];
    end else begin
      st2 = st; v2 = v; a2 = a[A2-1:0]; d2 = d[D2-1:0];
    end
  endtask

  task automatic get_out(input int sel, output logic busy, output logic done, output logic pass,
                         output logic blink, output int ec);
    if (sel == 1) begin
      busy = busy1; done = done1; pass = pass1; blink = blink1; ec = int'(ec1);
    end else begin
      busy = busy2; done = done2; pass = pass2; blink = blink2; ec = int'(ec2);
    end
  endtask

  // Reference: sample k is wrong when its address is not k or its data is not k's low bits
  function automatic bit is_bad(input int k, input int dw);
    return (s_addr[k] != k) || (s_data[k] != (k % (1 << dw)));
  endfunction

  function automatic int model_errs(input int n, input int aw, input int dw);
    int c = 0;
    for (int k = 0; k < n; k++) if (is_bad(k, dw)) c++;
    if (c > (1 << (aw + 1)) - 1) c = (1 << (aw + 1)) - 1;
    return c;
  endfunction

  task automatic start_pass(input int sel);
    logic b, dn, p, bl;
    int ec;
    @(negedge clk);
    set_in(sel, 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    set_in(sel, 1'b0, 1'b0, 0, 0);
    get_out(sel, b, dn, p, bl, ec);
    vecs++;
    if (b !== 1'b1 || dn !== 1'b0 || ec !== 0 || bl !== 1'b0) begin
      errs++;
      $display("FAIL start_armed dut%0d: busy=%b done=%b err=%0d blink=%b, want busy=1 done=0 err=0 blink=0",
               sel, b, dn, ec, bl);
    end
  endtask

  task automatic drive_pass(input int sel, input int n);
    logic b, dn, p, bl;
    int ec;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == n - 1) begin
        get_out(sel, b, dn, p, bl, ec);
        vecs++;
        if (b !== 1'b1 || dn !== 1'b0) begin
          errs++;
          $display("FAIL pre_last dut%0d: busy=%b done=%b, want busy=1 done=0", sel, b, dn);
        end
      end
      set_in(sel, 1'b0, 1'b1, s_addr[k], s_data[k]);
    end
    @(negedge clk);
    set_in(sel, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_verdict(input int sel, input string name, input int n, input int aw,
                               input int dw, input int bc, input int ncyc);
    logic b, dn, p, bl;
    int ec, exp_ec, want_bl;
    bit exp_pass;
    exp_ec   = model_errs(n, aw, dw);
    exp_pass = (exp_ec == 0);
    get_out(sel, b, dn, p, bl, ec);
    vecs++;
    if (ec !== exp_ec) begin
      errs++;
      $display("FAIL %s err_count dut%0d: got %0d want %0d", name, sel, ec, exp_ec);
    end
    vecs++;
    if (dn !== 1'b1 || p !== exp_pass || b !== 1'b0) begin
      errs++;
      $display("FAIL %s verdict dut%0d: done=%b pass=%b busy=%b, want done=1 pass=%b busy=0",
               name, sel, dn, p, b, exp_pass);
    end
`ifdef LUTRAM_CHECK_FIRST_ERR_EN
    begin
      int fa_exp = 0, fd_exp = 0, fa, fd;
      for (int k = n - 1; k >= 0; k--) if (is_bad(k, dw)) begin fa_exp = s_addr[k]; fd_exp = s_data[k]; end
      fa = (sel == 1) ? int'(fa1) : int'(fa2);
      fd = (sel == 1) ? int'(fd1) : int'(fd2);
      vecs++;
      if (fa !== fa_exp || fd !== fd_exp) begin
        errs++;
        $display("FAIL %s first_err dut%0d: addr=%0d data=%0d, want addr=%0d data=%0d",
                 name, sel, fa, fd, fa_exp, fd_exp);
      end
    end
`endif
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      get_out(sel, b, dn, p, bl, ec);
      want_bl = exp_pass ? 1 : ((k / bc) % 2);
      vecs++;
      if (bl !== want_bl[0] || dn !== 1'b1) begin
        errs++;
        $display("FAIL %s blink dut%0d cycle %0d: blink=%b done=%b, want blink=%0d done=1",
                 name, sel, k, bl, dn, want_bl);
      end
    end
  endtask

  task automatic fill_clean(input int n, input int dw);
    for (int k = 0; k < n; k++) begin s_addr[k] = k; s_data[k] = k % (1 << dw); end
  endtask

  task automatic check_all_zero(input string name);
    vecs++;
    if ({busy1, done1, pass1, blink1, busy2, done2, pass2, blink2} !== 8'h00 || ec1 !== '0 || ec2 !== '0) begin
      errs++;
      $display("FAIL %s: dut1 b/d/p/bl=%b%b%b%b err=%0d dut2 b/d/p/bl=%b%b%b%b err=%0d, want all 0",
               name, busy1, done1, pass1, blink1, ec1, busy2, done2, pass2, blink2, ec2);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_in(1, 1'b0, 1'b0, 0, 0);
    set_in(2, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      set_in(1, 1'b0, 1'b1, k, k + 1);
      set_in(2, 1'b0, 1'b1, k % 4, 7);
    end
    @(negedge clk);
    set_in(1, 1'b0, 1'b0, 0, 0);
    set_in(2, 1'b0, 1'b0, 0, 0);
    check_all_zero("idle_ignores_valid");
  endtask

  task automatic test_clean_pass;
    fill_clean(N1, D1);
    start_pass(1);
    drive_pass(1, N1);
    check_verdict(1, "clean", N1, A1, D1, B1, 6);
  endtask

  task automatic test_data_error;
    fill_clean(N1, D1);
    s_data[17] = s_data[17] ^ 1;
    start_pass(1);
    drive_pass(1, N1);
    check_verdict(1, "data_err", N1, A1, D1, B1, 3 * B1 + 2);
  endtask

  task automatic test_sequence_error;
    for (int k = 0; k < N1; k++) begin
      s_addr[k] = (k <= 5) ? k : k - 1;
      s_data[k] = s_addr[k] % 2;
    end
    start_pass(1);
    drive_pass(1, N1);
    check_verdict(1, "seq_err", N1, A1, D1, B1, 2);
  endtask

  task automatic test_saturation;
    for (int k = 0; k < N2; k++) begin s_addr[k] = k; s_data[k] = (~k) & 7; end
    start_pass(2);
    drive_pass(2, N2);
    check_verdict(2, "all_wrong", N2, A2, D2, B2, 3 * B2 + 1);
  endtask

  task automatic test_priority_restart;
    for (int k = 0; k < 10; k++) begin s_addr[k] = k; s_data[k] = (k % 2) ^ 1; end
    start_pass(1);
    drive_pass(1, 10);
    vecs++;
    if (ec1 !== 7'd10 || busy1 !== 1'b1) begin
      errs++;
      $display("FAIL partial_count: err=%0d busy=%b, want err=10 busy=1", ec1, busy1);
    end
    @(negedge clk);
    set_in(1, 1'b1, 1'b1, 10, 0);
    @(negedge clk);
    set_in(1, 1'b0, 1'b0, 0, 0);
    vecs++;
    if (ec1 !== '0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
      errs++;
      $display("FAIL start_priority: err=%0d busy=%b done=%b, want err=0 busy=1 done=0", ec1, busy1, done1);
    end
    fill_clean(N1, D1);
    drive_pass(1, N1);
    check_verdict(1, "after_restart", N1, A1, D1, B1, 2);
  endtask

  task automatic test_random;
    int sel, n, aw, dw, bc, m;
    for (int r = 0; r < 10; r++) begin
      sel = (r % 2) + 1;
      n   = (sel == 1) ? N1 : N2;
      aw  = (sel == 1) ? A1 : A2;
      dw  = (sel == 1) ? D1 : D2;
      bc  = (sel == 1) ? B1 : B2;
      for (int k = 0; k < n; k++) begin
        m = $urandom_range(0, (sel == 1) ? 39 : 5);
        s_addr[k] = (m == 0) ? $urandom_range(0, n - 1) : k;
        s_data[k] = (m == 1) ? $urandom_range(0, (1 << dw) - 1) : k % (1 << dw);
      end
      start_pass(sel);
      drive_pass(sel, n);
      check_verdict(sel, "random", n, aw, dw, bc, 2 * bc + 1);
    end
  endtask

  task automatic test_reset_mid_pass;
    for (int k = 0; k < 20; k++) begin s_addr[k] = k; s_data[k] = (k % 2) ^ (k % 3 == 0 ? 1 : 0); end
    start_pass(1);
    drive_pass(1, 20);
    for (int k = 0; k < 2; k++) begin s_addr[k] = k; s_data[k] = 5; end
    start_pass(2);
    drive_pass(2, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_mid_pass");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_in(1, 1'b0, 1'b1, k, 1);
      set_in(2, 1'b0, 1'b1, k, 0);
    end
    @(negedge clk);
    set_in(1, 1'b0, 1'b0, 0, 0);
    set_in(2, 1'b0, 1'b0, 0, 0);
    check_all_zero("idle_after_reset");
  endtask

  initial begin
    test_reset;
    test_clean_pass;
    test_data_error;
    test_sequence_error;
    test_saturation;
    test_priority_restart;
    test_random;
    test_reset_mid_pass;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/lutram_readback_checker.md
Name: lutram_readback_checker

Overview:
- Consumes the read-phase output stream of a single-port LUTRAM test stage.
- The upstream stage writes address-LSB data, then reads back 2**A_WIDTH words.
- Compares each readback word against the expected pattern, counts mismatches and address-sequence errors, and reports the verdict.
- Verdict is presented as a level and as a pin-friendly blink signal for board observation.

Parameters:
- A_WIDTH, 6, address width of the RAM under test; one pass checks 2**A_WIDTH samples.
- D_WIDTH, 1, readback data width.
- BLINK_CYCLES, 24'd12500000, clock cycles per toggle half-period of blink_o on FAIL; must be >= 1.

Ports:
- clk_i  input  1  single clock; all state on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  one-cycle pulse; clears results and arms a new check pass.
- valid_i  input  1  sample strobe; one per read address.
- addr_i  input  A_WIDTH  address the sample was read from.
- data_i  input  D_WIDTH  RAM readback data.
- busy_o  output  1  high in CHECK.
- done_o  output  1  high in PASS or FAIL.
- pass_o  output  1  high in PASS only.
- err_count_o  output  A_WIDTH+1  erroneous samples in the current/last pass.
- blink_o  output  1  PASS: constant 1; FAIL: square wave; otherwise 0.

Behaviour:
- Asynchronous reset (rst_ni low):
  - state=IDLE.
  - busy_o=0, done_o=0, pass_o=0, blink_o=0.
  - err_count_o=0; sample index=0; blink counter=0.
- States: IDLE, CHECK, PASS, FAIL.
- Transitions:
  - start_i in any state -> CHECK; clears err_count_o, sample index, blink counter and blink_o. start_i has priority: a coincident valid_i is dropped.
  - IDLE: valid_i is ignored.
  - CHECK: each valid_i sample is evaluated against the sample index idx.
    - Expected data = {addr zero-extended to max(A_WIDTH,D_WIDTH)}[D_WIDTH-1:0]; for D_WIDTH=1 this is idx[0].
    - A sample is erroneous if addr_i != idx (sequence error) or data_i != expected(idx).
    - Each sample counts at most once; err_count_o increments by 1 and saturates at all-ones.
  - Ending the pass:
    - The sample with idx == 2**A_WIDTH-1 ends the pass.
    - The next state is PASS if the total error count, including that sample, is 0, else FAIL.
    - done_o rises on the cycle after that valid_i edge (1-cycle latency); err_count_o is final on that same cycle.
  - idx increments per accepted sample and is A_WIDTH+1 bits wide; it does not wrap within a pass.
  - PASS/FAIL: valid_i is ignored. The state holds until start_i or reset.
- blink_o in FAIL:
  - The counter counts 0..BLINK_CYCLES-1.
  - At terminal count, blink_o toggles and the counter returns to 0.
  - First toggle to 1 occurs BLINK_CYCLES cycles after entering FAIL.
- Reset mid-pass: all results are lost and the block returns to IDLE; there is no partial verdict.
- valid_i held high for consecutive cycles: each cycle is a separate sample.

Optional Feature:
- Macro: LUTRAM_CHECK_FIRST_ERR_EN.
- Defined: adds ports first_err_addr_o (A_WIDTH) and first_err_data_o (D_WIDTH).
  - These latch addr_i/data_i of the first erroneous sample in a pass.
  - Both are 0 after reset and start_i, and are held unchanged by later errors.
- Not defined: those ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Clean pass (A_WIDTH=6, D_WIDTH=1): reset, start_i, 64 samples addr 0..63 with data=addr[0] -> done_o=1 and pass_o=1 one cycle after the 64th sample; err_count_o=0; blink_o=1.
- Single data error: as above, but flip data at addr 17 -> FAIL; err_count_o=1; pass_o=0. With LUTRAM_CHECK_FIRST_ERR_EN, first_err_addr_o=17 and first_err_data_o=0. With BLINK_CYCLES=4, blink_o toggles every 4 cycles, first rising 4 cycles after done_o.
- Sequence error: send addr 5 twice (skip 6), correct data for the sent address -> every sample from idx 6 onward counts as a sequence error; err_count_o=58; FAIL.
- All wrong with saturation (A_WIDTH=2): 4 samples, all inverted data -> err_count_o=4 (3'b100), no overflow.
- Priority/restart: start_i coincident with valid_i at sample 10 -> sample dropped, err_count_o=0, idx=0. Then assert rst_ni low mid-pass -> all outputs 0 immediately (asynchronous), state IDLE; valid_i afterwards has no effect until start_i.
